// File: rtl/fanin_link_arbiter_pkg.sv
// Shared types and helpers for the fan-in link arbiter slice.
// Forward tokens are flattened as {v, data}; back-prop tokens as {n, r}.
package fanin_link_arbiter_pkg;

  localparam int unsigned BTK_W = 2;

  typedef enum logic [1:0] {
    aRB_IDLE,
    aRB_GRANT,
    aRB_RELEASE
  } fsm_fanin_arb;

  typedef struct packed {
    logic n;
    logic r;
  } BTk_t;

  function automatic int unsigned ftk_w(input int unsigned width_data);
    return width_data + 1;
  endfunction

  function automatic int unsigned sel_w(input int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/fanin_link_arbiter_rr_pick.sv
// Combinational round-robin select: first asserted request at or after
// the pointer, wrapping. Shared with fan-out arbitration.
module fanin_link_arbiter_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_valid,
  output logic [PW-1:0] o_idx
);

  always_comb begin
    int unsigned c;
    o_valid = 1'b0;
    o_idx   = '0;
    c       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = 32'(i_ptr) + k;
      if (c >= N) c = c - N;
      if (!o_valid && i_req[c[PW-1:0]]) begin
        o_valid = 1'b1;
        o_idx   = c[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/fanin_link_arbiter.sv
// Fan-in link arbiter: round-robin path grant, forward-token mux,
// back-prop steering, and the shared Next-ID register with dirty bit.
module fanin_link_arbiter
  import fanin_link_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned WIDTH_DATA = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_IN*(WIDTH_DATA+1)-1:0] I_FTk,
  output logic [NUM_IN*BTK_W-1:0]        O_BTk,
  output logic [WIDTH_DATA:0]            O_FTk,
  input  logic [BTK_W-1:0]               I_BTk,
  input  logic [NUM_IN-1:0]              I_Req,
  input  logic [NUM_IN-1:0]              I_Trm,
  output logic [NUM_IN-1:0]              O_Grt,
  output logic                           O_Rls,
  input  logic [NUM_IN-1:0]              I_WeId,
  input  logic [NUM_IN*WIDTH_DATA-1:0]   I_NextID_t,
  input  logic [NUM_IN*WIDTH_DATA-1:0]   I_NextID_f,
  input  logic [NUM_IN-1:0]              I_Cond,
  input  logic                           I_Clr,
  output logic [WIDTH_DATA-1:0]          O_Next,
  output logic                           O_DirtyBit
);

  localparam int unsigned FW = ftk_w(WIDTH_DATA);
  localparam int unsigned SW = sel_w(NUM_IN);

  fsm_fanin_arb          r_state;
  fsm_fanin_arb          w_state_nxt;
  logic [SW-1:0]         r_sel;
  logic [SW-1:0]         w_sel_nxt;
  logic [SW-1:0]         r_ptr;
  logic [SW-1:0]         w_ptr_nxt;
  logic [WIDTH_DATA-1:0] r_next;
  logic                  r_dirty;

  logic                  w_pick_valid;
  logic [SW-1:0]         w_pick_idx;
  logic                  w_granted;
  logic                  w_exit;
  logic                  w_capture;
  logic [WIDTH_DATA-1:0] w_next_val;
  BTk_t                  w_btk;

  assign w_btk     = BTk_t'(I_BTk);
  assign w_granted = (r_state == aRB_GRANT);
  // Termination is held off while downstream nacks; a dropped request aborts.
  assign w_exit    = (I_Trm[r_sel] & ~w_btk.n) | ~I_Req[r_sel];
  assign w_capture = w_granted & I_WeId[r_sel];
  assign w_next_val = I_Cond[r_sel] ? I_NextID_t[r_sel*WIDTH_DATA +: WIDTH_DATA]
                                    : I_NextID_f[r_sel*WIDTH_DATA +: WIDTH_DATA];

  fanin_link_arbiter_rr_pick #(
    .N  (NUM_IN),
    .PW (SW)
  ) u_rr_pick (
    .i_req   (I_Req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= aRB_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      aRB_IDLE: begin
        if (w_pick_valid) begin
          w_sel_nxt   = w_pick_idx;
          w_state_nxt = aRB_GRANT;
        end
      end
      aRB_GRANT: begin
        if (w_exit) begin
          w_state_nxt = aRB_RELEASE;
          w_ptr_nxt   = (r_sel == SW'(NUM_IN - 1)) ? '0 : r_sel + SW'(1);
        end
      end
      aRB_RELEASE: w_state_nxt = aRB_IDLE;
      default:     w_state_nxt = aRB_IDLE;
    endcase
  end

  assign O_Rls = (r_state == aRB_RELEASE);

  always_comb begin
    O_Grt = '0;
    O_FTk = '0;
    O_BTk = '0;
    if (w_granted) begin
      O_Grt[r_sel] = 1'b1;
      O_FTk        = I_FTk[r_sel*FW +: FW];
    end
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (w_granted && (SW'(i) == r_sel)) begin
        O_BTk[i*BTK_W +: BTK_W] = w_btk;
      end else if (I_Req[i]) begin
        O_BTk[i*BTK_W +: BTK_W] = BTk_t'{n: 1'b1, r: 1'b0};
      end
    end
  end

  // A capture in the same cycle as I_Clr leaves the dirty bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_next  <= '0;
      r_dirty <= 1'b0;
    end else if (w_capture) begin
      r_next  <= w_next_val;
      r_dirty <= 1'b1;
    end else if (I_Clr) begin
      r_dirty <= 1'b0;
    end
  end

  assign O_Next     = r_next;
  assign O_DirtyBit = r_dirty;

endmodule

// File: tb/tb_fanin_link_arbiter.sv
// Scoreboard bench for fanin_link_arbiter: stimulus queues expected grant/
// release events and Next-ID updates; a negedge monitor pops and compares.
module tb_fanin_link_arbiter;

  localparam int N  = 4;
  localparam int WD = 32;
  localparam int FW = WD + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [FW-1:0]     ftk [N];
  logic [N*FW-1:0]   I_FTk;
  logic [N*2-1:0]    O_BTk;
  logic [FW-1:0]     O_FTk;
  logic [1:0]        I_BTk;
  logic [N-1:0]      I_Req, I_Trm, O_Grt, I_WeId, I_Cond;
  logic              O_Rls, I_Clr, O_DirtyBit;
  logic [WD-1:0]     nid_t [N];
  logic [WD-1:0]     nid_f [N];
  logic [N*WD-1:0]   I_NextID_t, I_NextID_f;
  logic [WD-1:0]     O_Next;

  always_comb begin
    I_FTk      = '0;
    I_NextID_t = '0;
    I_NextID_f = '0;
    for (int i = 0; i < N; i++) begin
      I_FTk[i*FW +: FW]      = ftk[i];
      I_NextID_t[i*WD +: WD] = nid_t[i];
      I_NextID_f[i*WD +: WD] = nid_f[i];
    end
  end

  fanin_link_arbiter #(
    .NUM_IN     (N),
    .WIDTH_DATA (WD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .I_FTk      (I_FTk),
    .O_BTk      (O_BTk),
    .O_FTk      (O_FTk),
    .I_BTk      (I_BTk),
    .I_Req      (I_Req),
    .I_Trm      (I_Trm),
    .O_Grt      (O_Grt),
    .O_Rls      (O_Rls),
    .I_WeId     (I_WeId),
    .I_NextID_t (I_NextID_t),
    .I_NextID_f (I_NextID_f),
    .I_Cond     (I_Cond),
    .I_Clr      (I_Clr),
    .O_Next     (O_Next),
    .O_DirtyBit (O_DirtyBit)
  );

  always #5 clock = ~clock;

  typedef struct { bit rls; int port; } ev_t;
  typedef struct { logic [WD-1:0] nxt; logic dirty; } id_t;
  ev_t ev_q[$];
  id_t id_q[$];

  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 1'b0;
  logic [N-1:0] prev_grt;
  logic [WD:0]  prev_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic exp_grant(input int p);
    ev_q.push_back('{rls: 1'b0, port: p});
  endtask

  task automatic exp_rls();
    ev_q.push_back('{rls: 1'b1, port: -1});
  endtask

  task automatic exp_id(input logic [WD-1:0] nxt, input logic dirty);
    id_q.push_back('{nxt: nxt, dirty: dirty});
  endtask

  always @(negedge clock) begin : monitor
    ev_t e;
    id_t d;
    if (mon_en) begin
      if (O_Grt != '0 && prev_grt == '0) begin
        if (ev_q.size() == 0) chk("unexpected_grant", 64'(O_Grt), 64'd0);
        else begin
          e = ev_q.pop_front();
          chk("event_kind_grant", 64'(e.rls), 64'd0);
          chk("grant_port", 64'(O_Grt), 64'(1) << e.port);
        end
      end
      if (O_Rls) begin
        if (ev_q.size() == 0) chk("unexpected_release", 64'(O_Rls), 64'd0);
        else begin
          e = ev_q.pop_front();
          chk("event_kind_release", 64'(e.rls), 64'd1);
          chk("grant_during_release", 64'(O_Grt), 64'd0);
        end
      end
      if ({O_Next, O_DirtyBit} !== prev_id) begin
        if (id_q.size() == 0) chk("unexpected_id_change", 64'({O_Next, O_DirtyBit}), 64'(prev_id));
        else begin
          d = id_q.pop_front();
          chk("next_id", 64'(O_Next), 64'(d.nxt));
          chk("dirty_bit", 64'(O_DirtyBit), 64'(d.dirty));
        end
      end
      prev_grt = O_Grt;
      prev_id  = {O_Next, O_DirtyBit};
    end
  end

  initial begin
    int p;
    reset  = 1'b1;
    I_BTk  = '0; I_Req = '0; I_Trm = '0; I_WeId = '0; I_Cond = '0; I_Clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      ftk[i]   = {1'b1, 32'hF000_0000 | 32'(i)};
      nid_t[i] = '0;
      nid_f[i] = '0;
    end
    step(2);
    chk("rst_grt",   64'(O_Grt), 64'd0);
    chk("rst_rls",   64'(O_Rls), 64'd0);
    chk("rst_ftk",   64'(O_FTk), 64'd0);
    chk("rst_btk",   64'(O_BTk), 64'd0);
    chk("rst_next",  64'(O_Next), 64'd0);
    chk("rst_dirty", 64'(O_DirtyBit), 64'd0);
    prev_grt = O_Grt;
    prev_id  = {O_Next, O_DirtyBit};
    mon_en   = 1'b1;
    reset    = 1'b0;
    step(1);

    // Contention: all ports requesting, each terminates after 3 grant cycles
    I_Req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      p = g % N;
      exp_grant(p);
      exp_rls();
      step(1);
      chk("rr_ftk", 64'(O_FTk), 64'(ftk[p]));
      if (g == 0) chk("rr_btk_nack_others", 64'(O_BTk), 64'hA8);
      step(2);
      I_Trm = 4'(1 << p);
      step(1);
      chk("rr_rls", 64'(O_Rls), 64'd1);
      I_Trm = '0;
      step(1);
      chk("rr_rls_one_cycle", 64'(O_Rls), 64'd0);
    end
    I_Req = '0;

    // Single requester on port 2
    I_BTk = 2'b01;
    I_Req = 4'b0100;
    exp_grant(2);
    exp_rls();
    step(1);
    chk("single_ftk", 64'(O_FTk), 64'(ftk[2]));
    chk("single_btk", 64'(O_BTk), 64'h10);
    step(3);
    I_Trm = 4'b0100;
    step(1);
    chk("single_rls", 64'(O_Rls), 64'd1);
    chk("single_rls_ftk", 64'(O_FTk), 64'd0);
    I_Trm = '0; I_Req = '0; I_BTk = '0;
    step(1);
    chk("single_idle_rls", 64'(O_Rls), 64'd0);
    chk("single_idle_grt", 64'(O_Grt), 64'd0);
    chk("single_idle_ftk", 64'(O_FTk), 64'd0);

    // Back-pressure: port 1 granted, nack holds off termination, port 3 waits
    I_Req = 4'b0010;
    exp_grant(1);
    step(1);
    I_Req = 4'b1010; I_BTk = 2'b10; I_Trm = 4'b0010;
    step(1);
    chk("bp_hold_grt", 64'(O_Grt), 64'h2);
    chk("bp_hold_rls", 64'(O_Rls), 64'd0);
    chk("bp_btk", 64'(O_BTk), 64'h88);
    chk("bp_ftk", 64'(O_FTk), 64'(ftk[1]));
    step(1);
    chk("bp_hold_grt2", 64'(O_Grt), 64'h2);
    I_BTk = '0;
    exp_rls();
    step(1);
    chk("bp_rls", 64'(O_Rls), 64'd1);
    I_Req = 4'b1000; I_Trm = '0;
    exp_grant(3);
    step(1);
    chk("bp_idle_after_rls", 64'(O_Grt), 64'd0);
    step(1);
    I_Trm = 4'b1000;
    exp_rls();
    step(1);
    I_Req = '0; I_Trm = '0;
    step(1);

    // Next-ID capture on port 0
    I_Req = 4'b0001;
    exp_grant(0);
    step(1);
    nid_t[0] = 32'h15; nid_f[0] = 32'h2A;
    I_WeId = 4'b0001; I_Cond = 4'b0001;
    exp_id(32'h15, 1'b1);
    step(1);
    I_Cond = 4'b0000;
    exp_id(32'h2A, 1'b1);
    step(1);
    I_WeId = '0;
    chk("nid_false_path", 64'(O_Next), 64'h2A);
    nid_t[2] = 32'h77; nid_f[2] = 32'h88;
    I_WeId = 4'b0100; I_Cond = 4'b0100;
    step(1);
    I_WeId = '0;
    chk("nid_ungranted_ignored", 64'(O_Next), 64'h2A);
    chk("nid_ungranted_dirty", 64'(O_DirtyBit), 64'd1);
    I_Clr = 1'b1; I_WeId = 4'b0001; I_Cond = 4'b0001;
    exp_id(32'h15, 1'b1);
    step(1);
    chk("clr_vs_capture", 64'(O_DirtyBit), 64'd1);
    I_WeId = '0;
    exp_id(32'h15, 1'b0);
    step(1);
    I_Clr = 1'b0;
    chk("clr_holds_next", 64'(O_Next), 64'h15);

    // Abort: request dropped without termination
    I_Req = '0;
    exp_rls();
    step(1);
    chk("abort_rls", 64'(O_Rls), 64'd1);
    step(1);
    chk("abort_rls_one_cycle", 64'(O_Rls), 64'd0);

    // Reset while granted
    I_Req = 4'b0100;
    exp_grant(2);
    step(1);
    I_WeId = 4'b0100; I_Cond = 4'b0100;
    exp_id(32'h77, 1'b1);
    step(1);
    I_WeId = '0; I_Cond = '0;
    reset = 1'b1; I_Req = '0;
    exp_id(32'h0, 1'b0);
    step(1);
    chk("rstg_grt",   64'(O_Grt), 64'd0);
    chk("rstg_rls",   64'(O_Rls), 64'd0);
    chk("rstg_ftk",   64'(O_FTk), 64'd0);
    chk("rstg_dirty", 64'(O_DirtyBit), 64'd0);
    step(1);
    chk("rstg_no_rls", 64'(O_Rls), 64'd0);
    reset = 1'b0;
    I_Req = 4'b1111;
    exp_grant(0);
    exp_rls();
    step(2);
    I_Trm = 4'b0001;
    step(1);
    I_Trm = '0; I_Req = '0;
    step(2);

    chk("event_queue_drained", 64'(ev_q.size()), 64'd0);
    chk("id_queue_drained", 64'(id_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
